// File: rtl/lut_function_unit.sv
// Programmable N_IN-input boolean function: synchronised, debounced switches index a writable truth table, plus a minterm-count sweep.
// Optional edge_pulse output on LEDR changes is enabled by defining LUT_FUNCTION_UNIT_EDGE_EN.
module lut_function_unit #(
  parameter int                      N_IN            = 4,
  parameter int                      DEBOUNCE_CYCLES = 16,
  parameter logic [(1<<N_IN)-1:0]    TT_INIT         = 16'h28AE
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic [N_IN-1:0] SW,
  input  logic            start,
  input  logic            tt_wr,
  input  logic [N_IN-1:0] tt_addr,
  input  logic            tt_data,
  output logic            LEDR,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   count
`ifdef LUT_FUNCTION_UNIT_EDGE_EN
  ,
  output logic            edge_pulse
`endif
);

  localparam int DEPTH = 1 << N_IN;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_IN-1:0]  ADDR_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t            state, state_next;
  logic [N_IN-1:0]   s1, s2, s2_prev, db;
  logic [CNT_W-1:0]  cnt;
  logic [DEPTH-1:0]  tt;
  logic [N_IN-1:0]   addr;
  logic [N_IN:0]     acc;
  logic [N_IN:0]     tt_bit;

  assign tt_bit = {{N_IN{1'b0}}, tt[addr]};

  // Two-flop synchroniser, then a stability counter that must saturate before db follows.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      s2_prev <= '0;
      db      <= '0;
      cnt     <= '0;
    end else begin
      s1      <= SW;
      s2      <= s1;
      s2_prev <= s2;
      if (s2 != db && s2 == s2_prev) begin
        if (cnt == CNT_MAX) begin
          db  <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Table writes are locked out for the whole sweep so the count is self-consistent.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tt   <= TT_INIT;
      LEDR <= 1'b0;
    end else begin
      LEDR <= tt[db];
      if (tt_wr && !busy)
        tt[tt_addr] <= tt_data;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SWEEP;
      SWEEP:   if (addr == ADDR_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      addr  <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr <= '0;
            acc  <= '0;
            busy <= 1'b1;
          end
        end
        SWEEP: begin
          acc <= acc + tt_bit;
          if (addr == ADDR_LAST) begin
            count <= acc + tt_bit;
            done  <= 1'b1;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        DONE:    busy <= 1'b0;
        default: busy <= 1'b0;
      endcase
    end
  end

`ifdef LUT_FUNCTION_UNIT_EDGE_EN
  logic ledr_prev;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ledr_prev  <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      ledr_prev  <= LEDR;
      edge_pulse <= LEDR ^ ledr_prev;
    end
  end
`endif

endmodule
